// File: rtl/calc_pkg.sv
// Shared constants and types for the calc port response tracker.
package calc_pkg;

    localparam int unsigned ENV_CMD_SIZE  = 4;
    localparam int unsigned ENV_DATA_SIZE = 32;
    localparam int unsigned LAT_W         = 10;
    localparam int unsigned TAG_W         = 2;
    localparam int unsigned NUM_TAGS      = 4;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2,
        RESP_BAD  = 2'd3
    } resp_e;

    typedef enum logic [ENV_CMD_SIZE-1:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        SHL = 4'd5,
        SHR = 4'd6
    } cmd_e;

    typedef enum logic {
        SLOT_FREE    = 1'b0,
        SLOT_PENDING = 1'b1
    } slot_state_e;

    // One completion record as seen on the done_* outputs.
    typedef struct packed {
        logic [ENV_CMD_SIZE-1:0]  cmd;
        logic [TAG_W-1:0]         tag;
        logic [1:0]               resp;
        logic [ENV_DATA_SIZE-1:0] data;
        logic [LAT_W-1:0]         latency;
    } done_rec_t;

endpackage

// File: rtl/calc_tag_slot.sv
// One tag slot: FREE/PENDING state, stored command and saturating age.
module calc_tag_slot
    import calc_pkg::*;
#(
    parameter int unsigned CMD_W = 4,
    parameter int unsigned AGE_W = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             alloc_i,
    input  logic             free_i,
    input  logic             timeout_hit_i,
    input  logic [CMD_W-1:0] cmd_i,
    output logic             pending_o,
    output logic [CMD_W-1:0] cmd_o,
    output logic [AGE_W-1:0] age_o
);

    slot_state_e      state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [AGE_W-1:0] age_q, age_d;

    // Slot state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= SLOT_FREE;
            cmd_q   <= '0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            age_q   <= age_d;
        end
    end

    // Allocation wins over free so a same-cycle completion can be reused at once;
    // a slot sitting at its timeout holds its age until the arbiter drains it.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        age_d   = age_q;
        unique case (state_q)
            SLOT_FREE: begin
                if (alloc_i) begin
                    state_d = SLOT_PENDING;
                    cmd_d   = cmd_i;
                    age_d   = AGE_W'(1);
                end
            end
            SLOT_PENDING: begin
                if (alloc_i) begin
                    cmd_d = cmd_i;
                    age_d = AGE_W'(1);
                end else if (free_i) begin
                    state_d = SLOT_FREE;
                    age_d   = '0;
                end else if (!timeout_hit_i && (age_q != '1)) begin
                    age_d = age_q + AGE_W'(1);
                end
            end
            default: state_d = SLOT_FREE;
        endcase
    end

    assign pending_o = (state_q == SLOT_PENDING);
    assign cmd_o     = cmd_q;
    assign age_o     = age_q;

endmodule

// File: rtl/calc_resp_tracker.sv
// Passive per-port tracker: pairs DUT responses with tagged commands,
// times out lost ones and emits one registered completion per command.
module calc_resp_tracker #(
    parameter int unsigned ENV_CMD_SIZE  = calc_pkg::ENV_CMD_SIZE,
    parameter int unsigned ENV_DATA_SIZE = calc_pkg::ENV_DATA_SIZE,
    parameter int unsigned TIMEOUT       = 100,
    parameter int unsigned LAT_W         = calc_pkg::LAT_W
) (
    input  logic                     PClk,
    input  logic                     reset,
    input  logic [ENV_CMD_SIZE-1:0]  req_cmd_in,
    input  logic [1:0]               req_tag_in,
    input  logic [1:0]               out_resp,
    input  logic [ENV_DATA_SIZE-1:0] out_data,
    input  logic [1:0]               out_tag,
    output logic                     done_valid,
    output logic [ENV_CMD_SIZE-1:0]  done_cmd,
    output logic [1:0]               done_tag,
    output logic [1:0]               done_resp,
    output logic [ENV_DATA_SIZE-1:0] done_data,
    output logic [LAT_W-1:0]         done_latency,
    output logic                     err_tag_reuse,
    output logic                     err_unexpected,
    output logic                     err_timeout,
    output logic                     err_bad_resp,
    output logic [2:0]               outstanding
);

    import calc_pkg::NUM_TAGS;
    import calc_pkg::TAG_W;
    import calc_pkg::RESP_NONE;
    import calc_pkg::RESP_BAD;

    logic [NUM_TAGS-1:0]     pending;
    logic [NUM_TAGS-1:0]     alloc;
    logic [NUM_TAGS-1:0]     free;
    logic [NUM_TAGS-1:0]     timeout_hit;
    logic [ENV_CMD_SIZE-1:0] slot_cmd [NUM_TAGS];
    logic [LAT_W-1:0]        slot_age [NUM_TAGS];

    logic                     resp_hit, to_found, to_emit, req_valid;
    logic [TAG_W-1:0]         to_idx;
    logic [NUM_TAGS-1:0]      next_pend;

    logic                     done_valid_q, done_valid_d;
    logic [ENV_CMD_SIZE-1:0]  done_cmd_q, done_cmd_d;
    logic [1:0]               done_tag_q, done_tag_d;
    logic [1:0]               done_resp_q, done_resp_d;
    logic [ENV_DATA_SIZE-1:0] done_data_q, done_data_d;
    logic [LAT_W-1:0]         done_lat_q, done_lat_d;
    logic                     err_reuse_q, err_reuse_d;
    logic                     err_unexp_q, err_unexp_d;
    logic                     err_to_q, err_to_d;
    logic                     err_bad_q, err_bad_d;
    logic [2:0]               outst_q, outst_d;

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_slot
        calc_tag_slot #(
            .CMD_W (ENV_CMD_SIZE),
            .AGE_W (LAT_W)
        ) u_slot (
            .clk_i         (PClk),
            .reset_i       (reset),
            .alloc_i       (alloc[g]),
            .free_i        (free[g]),
            .timeout_hit_i (timeout_hit[g]),
            .cmd_i         (req_cmd_in),
            .pending_o     (pending[g]),
            .cmd_o         (slot_cmd[g]),
            .age_o         (slot_age[g])
        );
    end

    // Response/timeout arbitration, slot control and next output record.
    always_comb begin
        resp_hit     = 1'b0;
        to_found     = 1'b0;
        to_emit      = 1'b0;
        to_idx       = '0;
        req_valid    = (req_cmd_in != '0);
        timeout_hit  = '0;
        free         = '0;
        alloc        = '0;
        next_pend    = '0;
        done_valid_d = 1'b0;
        done_cmd_d   = '0;
        done_tag_d   = '0;
        done_resp_d  = '0;
        done_data_d  = '0;
        done_lat_d   = '0;
        err_reuse_d  = 1'b0;
        err_unexp_d  = 1'b0;
        err_to_d     = 1'b0;
        err_bad_d    = (out_resp == RESP_BAD);
        outst_d      = '0;

        resp_hit    = (out_resp != RESP_NONE) && pending[out_tag];
        err_unexp_d = (out_resp != RESP_NONE) && !pending[out_tag];

        // Lowest pending tag at its limit, excluding one being answered now.
        for (int i = 0; i < NUM_TAGS; i++) begin
            timeout_hit[i] = pending[i] && (slot_age[i] == LAT_W'(TIMEOUT));
            if (timeout_hit[i] && !(resp_hit && (out_tag == TAG_W'(i))) && !to_found) begin
                to_found = 1'b1;
                to_idx   = TAG_W'(i);
            end
        end
        to_emit = to_found && !resp_hit;

        for (int i = 0; i < NUM_TAGS; i++) begin
            free[i] = (resp_hit && (out_tag == TAG_W'(i))) ||
                      (to_emit && (to_idx == TAG_W'(i)));
        end

        err_reuse_d = req_valid && pending[req_tag_in] && !free[req_tag_in];
        for (int i = 0; i < NUM_TAGS; i++) begin
            alloc[i]     = req_valid && (req_tag_in == TAG_W'(i)) && (!pending[i] || free[i]);
            next_pend[i] = alloc[i] || (pending[i] && !free[i]);
            outst_d      = outst_d + 3'(next_pend[i]);
        end

        if (resp_hit) begin
            done_valid_d = 1'b1;
            done_cmd_d   = slot_cmd[out_tag];
            done_tag_d   = out_tag;
            done_resp_d  = out_resp;
            done_data_d  = out_data;
            done_lat_d   = slot_age[out_tag];
        end else if (to_emit) begin
            done_valid_d = 1'b1;
            done_cmd_d   = slot_cmd[to_idx];
            done_tag_d   = to_idx;
            done_lat_d   = LAT_W'(TIMEOUT);
            err_to_d     = 1'b1;
        end
    end

    // Output registers; reset clears every record and flag.
    always_ff @(posedge PClk) begin
        if (reset) begin
            done_valid_q <= 1'b0;
            done_cmd_q   <= '0;
            done_tag_q   <= '0;
            done_resp_q  <= '0;
            done_data_q  <= '0;
            done_lat_q   <= '0;
            err_reuse_q  <= 1'b0;
            err_unexp_q  <= 1'b0;
            err_to_q     <= 1'b0;
            err_bad_q    <= 1'b0;
            outst_q      <= '0;
        end else begin
            done_valid_q <= done_valid_d;
            done_cmd_q   <= done_cmd_d;
            done_tag_q   <= done_tag_d;
            done_resp_q  <= done_resp_d;
            done_data_q  <= done_data_d;
            done_lat_q   <= done_lat_d;
            err_reuse_q  <= err_reuse_d;
            err_unexp_q  <= err_unexp_d;
            err_to_q     <= err_to_d;
            err_bad_q    <= err_bad_d;
            outst_q      <= outst_d;
        end
    end

    assign done_valid     = done_valid_q;
    assign done_cmd       = done_cmd_q;
    assign done_tag       = done_tag_q;
    assign done_resp      = done_resp_q;
    assign done_data      = done_data_q;
    assign done_latency   = done_lat_q;
    assign err_tag_reuse  = err_reuse_q;
    assign err_unexpected = err_unexp_q;
    assign err_timeout    = err_to_q;
    assign err_bad_resp   = err_bad_q;
    assign outstanding    = outst_q;

endmodule
